piso_shift: RTL and testbench



---
 rtl/piso_shift.sv | 114 +++++++++++
 tb/tb_piso_shift.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift.sv
// piso_shift: parallel-in / serial-out shifter feeding a negedge capture flop.
// A word is taken over a valid/ready handshake and driven out MSB first, one
// bit per falling edge of the clock. Back-to-back words stream with no gap:
// the next word is taken at the edge that shifts out the LSB of the current one.
//
// Handshake: a word moves when VALID and READY are both high at a falling
// clock edge. READY comes from registers only and never looks at VALID.
// VALID may drop without a transfer, and DIN is ignored except on that edge.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] DIN,
    input  logic             VALID,
    output logic             READY,
    output logic             SO,
    output logic             SVALID,
    output logic             SOF,
    output logic             BUSY,
    output logic             state_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               so_q, so_d;
    logic               svalid_q, svalid_d;
    logic               sof_q, sof_d;
    logic               accept;

    // Ready while idle, or while the LSB of the current word is on SO.
    assign READY   = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == '0));
    assign BUSY    = (state_q == SHIFT);
    assign accept  = VALID && READY;
    assign SO      = so_q;
    assign SVALID  = svalid_q;
    assign SOF     = sof_q;
    assign state_o = state_q;

    // Next-state logic: load on accept, shift while bits remain, else go idle.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        so_d     = so_q;
        svalid_d = svalid_q;
        sof_d    = sof_q;
        if (accept) begin
            // The same load serves the idle start and the gapless reload.
            state_d  = SHIFT;
            sr_d     = DIN;
            so_d     = DIN[WIDTH-1];
            svalid_d = 1'b1;
            sof_d    = 1'b1;
            cnt_d    = CNT_W'(WIDTH - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    so_d     = 1'b0;
                    svalid_d = 1'b0;
                    sof_d    = 1'b0;
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        sr_d     = sr_q << 1;
                        so_d     = sr_q[WIDTH-2];
                        cnt_d    = cnt_q - CNT_W'(1);
                        sof_d    = 1'b0;
                        svalid_d = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        so_d     = 1'b0;
                        svalid_d = 1'b0;
                        sof_d    = 1'b0;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    so_d     = 1'b0;
                    svalid_d = 1'b0;
                    sof_d    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers, updated on the falling edge; reset drops any partial word.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            so_q     <= 1'b0;
            svalid_q <= 1'b0;
            sof_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            so_q     <= so_d;
            svalid_q <= svalid_d;
            sof_q    <= sof_d;
        end
    end

endmodule

// File: tb/tb_piso_shift.sv
// Directed bench for piso_shift: reset, single word, back-to-back, stall,
// mid-word reset, and a capture-flop chain at WIDTH=2 and WIDTH=32.
module tb_piso_shift;

    // ---------------- clock / reset ----------------
    logic clk = 1'b1;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- WIDTH=8 instance ----------------
    logic [7:0] din8;
    logic       valid8, ready8, so8, svalid8, sof8, busy8, state8;

    piso_shift #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .DIN(din8), .VALID(valid8),
        .READY(ready8), .SO(so8), .SVALID(svalid8), .SOF(sof8),
        .BUSY(busy8), .state_o(state8)
    );

    // ---------------- WIDTH=2 instance ----------------
    logic [1:0] din2;
    logic       valid2, ready2, so2, svalid2, sof2, busy2, state2;

    piso_shift #(.WIDTH(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .DIN(din2), .VALID(valid2),
        .READY(ready2), .SO(so2), .SVALID(svalid2), .SOF(sof2),
        .BUSY(busy2), .state_o(state2)
    );

    // ---------------- WIDTH=32 instance ----------------
    logic [31:0] din32;
    logic        valid32, ready32, so32, svalid32, sof32, busy32, state32;

    piso_shift #(.WIDTH(32)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .DIN(din32), .VALID(valid32),
        .READY(ready32), .SO(so32), .SVALID(svalid32), .SOF(sof32),
        .BUSY(busy32), .state_o(state32)
    );

    // Downstream negedge capture flops fed by SO.
    logic q2 = 1'b0;
    logic q32 = 1'b0;
    always @(negedge clk) begin
        q2  <= so2;
        q32 <= so32;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle: outputs move at the falling edge, bench acts on the rising edge.
    task automatic step();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic chk_out8(input string tag, input logic so, input logic sof,
                            input logic rdy, input logic sv, input logic bsy);
        check({tag, ".so"},     {31'd0, so8},     {31'd0, so});
        check({tag, ".sof"},    {31'd0, sof8},    {31'd0, sof});
        check({tag, ".ready"},  {31'd0, ready8},  {31'd0, rdy});
        check({tag, ".svalid"}, {31'd0, svalid8}, {31'd0, sv});
        check({tag, ".busy"},   {31'd0, busy8},   {31'd0, bsy});
        check({tag, ".state"},  {31'd0, state8},  {31'd0, bsy});
    endtask

    // Send one word with VALID dropped right after acceptance; check all 8 bit
    // cycles and the idle cycle that follows.
    task automatic send_single(input logic [7:0] w, input string tag);
        din8   = w;
        valid8 = 1'b1;
        step();
        valid8 = 1'b0;
        din8   = ~w;
        for (int i = 0; i < 8; i++) begin
            chk_out8($sformatf("%s.b%0d", tag, i), w[7-i], (i == 0), (i == 7), 1'b1, 1'b1);
            step();
        end
        chk_out8({tag, ".end"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  wa;
        logic [7:0]  wb;
        logic [1:0]  words2[6];
        logic [31:0] words32[3];
        logic        bit_e;

        rst_n   = 1'b0;
        din8    = 8'hFF;
        valid8  = 1'b1;
        din2    = '0;
        valid2  = 1'b0;
        din32   = '0;
        valid32 = 1'b0;

        // Reset held with VALID high and DIN all ones.
        #1;
        chk_out8("rst0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out8($sformatf("rst%0d", i + 1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        rst_n  = 1'b1;
        valid8 = 1'b0;

        // Single word.
        send_single(8'hA5, "single");

        // Back-to-back 0xA5 then 0x3C with VALID held.
        wa     = 8'hA5;
        wb     = 8'h3C;
        din8   = wa;
        valid8 = 1'b1;
        step();
        din8 = wb;
        for (int i = 0; i < 16; i++) begin
            bit_e = (i < 8) ? wa[7-i] : wb[15-i];
            chk_out8($sformatf("b2b.b%0d", i), bit_e, (i == 0 || i == 8),
                     (i == 7 || i == 15), 1'b1, 1'b1);
            if (i == 8) begin
                valid8 = 1'b0;
                din8   = 8'hFF;
            end
            step();
        end
        chk_out8("b2b.end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Stall: 0xA5, three idle cycles with DIN toggling, then 0x0F.
        send_single(8'hA5, "stall_a");
        for (int j = 0; j < 2; j++) begin
            din8 = 8'($urandom_range(0, 255));
            step();
            chk_out8($sformatf("stall_idle%0d", j), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        send_single(8'h0F, "stall_b");

        // Reset mid-word after the third bit of 0xA5.
        wa     = 8'hA5;
        din8   = wa;
        valid8 = 1'b1;
        step();
        valid8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_out8($sformatf("midrst.b%0d", i), wa[7-i], (i == 0), 1'b0, 1'b1, 1'b1);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_out8("midrst.async", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk_out8("midrst.held", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        send_single(8'h81, "after_rst");

        // Chain at WIDTH=2: captured Q equals sent bits one edge later.
        exp_q.delete();
        for (int n = 0; n < 6; n++) begin
            words2[n] = 2'($urandom_range(0, 3));
            for (int b = 1; b >= 0; b--) exp_q.push_back(words2[n][b]);
        end
        din2   = words2[0];
        valid2 = 1'b1;
        step();
        for (int m = 0; m <= 12; m++) begin
            if (m > 0) check($sformatf("chain2.m%0d", m), {31'd0, q2}, {31'd0, exp_q.pop_front()});
            if (m / 2 + 1 < 6) din2 = words2[m / 2 + 1];
            else valid2 = 1'b0;
            step();
        end
        check("chain2.drained", exp_q.size(), 0);
        check("chain2.idle_sv", {31'd0, svalid2}, 32'd0);

        // Chain at WIDTH=32.
        exp_q.delete();
        for (int n = 0; n < 3; n++) begin
            words32[n] = $urandom;
            for (int b = 31; b >= 0; b--) exp_q.push_back(words32[n][b]);
        end
        din32   = words32[0];
        valid32 = 1'b1;
        step();
        for (int m = 0; m <= 96; m++) begin
            if (m > 0) check($sformatf("chain32.m%0d", m), {31'd0, q32}, {31'd0, exp_q.pop_front()});
            if (m == 0) check("chain32.sof", {31'd0, sof32}, 32'd1);
            if (m / 32 + 1 < 3) din32 = words32[m / 32 + 1];
            else valid32 = 1'b0;
            step();
        end
        check("chain32.drained", exp_q.size(), 0);
        check("chain32.idle_rdy", {31'd0, ready32}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
